// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port data RAM arbiter.
package ram_arbiter_pkg;

    // Tag of the access granted in the previous cycle: which port, if any,
    // expects read data this cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2
    } resp_state_t;

    // Port identifiers used to steer the granted request onto the RAM bus.
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/ram_arb_starve_cnt.sv
// Saturating count of consecutive cycles in which port B asked and was refused.
// Once the count reaches MAX_WAIT, port B gets priority over port A.
module ram_arb_starve_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic b_req,
    input  logic b_gnt,
    output logic starved
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] SAT = CW'(MAX_WAIT);

    logic [CW-1:0] count;

    // Count refused B cycles; any B grant or idle B cycle restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples values from before the edge, independent of block order.
        if (reset) begin
            count <= '0;
        end else if (!b_req || b_gnt) begin
            count <= '0;
        end else if (count != SAT) begin
            count <= count + 1'b1;
        end
    end

    assign starved = (count == SAT);

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter sharing one single-port RAM between the CPU data port (A) and a
// secondary master (B). One access per cycle, A has priority unless B has
// been starved; read data returns one cycle after the grant to its issuer.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 32768,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  a_gnt,
    output logic                  b_gnt,
    output logic                  a_rvalid,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  a_err,
    output logic                  b_err,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_in,
    output logic                  ram_load,
    input  logic [DATA_WIDTH-1:0] ram_out
);

    logic                  starved;
    logic                  sel_port;
    logic                  granted;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0] gnt_wdata;
    logic                  gnt_we;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  oor_q;
    resp_state_t           state;
    resp_state_t           next_state;

    ram_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk     (clk),
        .reset   (reset),
        .b_req   (b_req),
        .b_gnt   (b_gnt),
        .starved (starved)
    );

    // Grant decision: starved B first, then A, then B; nothing during reset.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves a value unassigned and no latch is inferred.
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!reset) begin
            if (b_req && starved) begin
                b_gnt = 1'b1;
            end else if (a_req) begin
                a_gnt = 1'b1;
            end else if (b_req) begin
                b_gnt = 1'b1;
            end
        end
    end

    assign sel_port  = b_gnt ? PORT_B : PORT_A;
    assign granted   = a_gnt | b_gnt;
    assign gnt_addr  = (sel_port == PORT_B) ? b_addr  : a_addr;
    assign gnt_wdata = (sel_port == PORT_B) ? b_wdata : a_wdata;
    assign gnt_we    = (sel_port == PORT_B) ? b_we    : a_we;
    assign in_range  = ({1'b0, gnt_addr} < (ADDR_WIDTH + 1)'(DEPTH));

    // The RAM bus follows the granted request and otherwise holds its last value.
    assign ram_address = granted ? gnt_addr  : addr_q;
    assign ram_in      = granted ? gnt_wdata : wdata_q;
    assign ram_load    = granted & gnt_we & in_range;

    // Remember the last granted address/data so the bus is stable when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (granted) begin
            addr_q  <= gnt_addr;
            wdata_q <= gnt_wdata;
        end
    end

    // Response tag register plus the out-of-range flag and error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            oor_q <= 1'b0;
            a_err <= 1'b0;
            b_err <= 1'b0;
        end else begin
            state <= next_state;
            oor_q <= granted & ~in_range;
            a_err <= a_gnt & ~in_range;
            b_err <= b_gnt & ~in_range;
        end
    end

    // Next tag from this cycle's read grant; route read data to the tagged port.
    always_comb begin
        next_state = IDLE;
        a_rvalid   = 1'b0;
        b_rvalid   = 1'b0;
        a_rdata    = '0;
        b_rdata    = '0;

        if (a_gnt && !a_we) begin
            next_state = RD_A;
        end else if (b_gnt && !b_we) begin
            next_state = RD_B;
        end

        case (state)
            RD_A: begin
                a_rvalid = 1'b1;
                a_rdata  = oor_q ? '0 : ram_out;
            end
            RD_B: begin
                b_rvalid = 1'b1;
                b_rdata  = oor_q ? '0 : ram_out;
            end
            default: ;
        endcase
    end

endmodule
